// File: rtl/mem_interface_unit_if.sv
// Byte-wide main-memory port between mem_interface_unit and the memory.
// master: the unit driving req/we/addr/wdata; slave: the memory returning ack/rdata.
// mem_req is held until mem_ack; mem_rdata is only meaningful in an ack cycle.
interface mem_interface_unit_if #(
    parameter int ADDR_W = 14
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_interface_unit.sv
// Converts level load/store requests into byte req/ack beats: a load reads one byte,
// a store writes result as two bytes (low at addr, high at addr+1). Zero-wait latency:
// mem_done two cycles (load) / three cycles (store) after the command edge is sampled.
// Each beat holds mem_req until mem_ack; a beat unacked for TIMEOUT_CYCLES aborts with mem_err.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   load_i, store_i     level requests; accepted on a rising edge while idle, load wins
//   addr_i, result_i    command address and store data, captured on acceptance
//   data_o              last successfully read byte
//   mem_done_o          one-cycle completion pulse
//   mem_err_o           one-cycle pulse with mem_done_o when a beat timed out
//   mem                 memory port (master side)
module mem_interface_unit #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_i,
    input  logic                   store_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [15:0]            result_i,
    output logic [7:0]             data_o,
    output logic                   mem_done_o,
    output logic                   mem_err_o,
    mem_interface_unit_if.master   mem
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WRITE_LO = 3'd2;
    localparam logic [2:0] S_WRITE_HI = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value in the last cycle a beat may wait before aborting.
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]        state_q,    state_d;
    logic              prev_req_q, prev_req_d;
    logic [7:0]        data_q,     data_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic              req_q,      req_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [7:0]        wdata_q,    wdata_d;
    logic [7:0]        res_hi_q,   res_hi_d;
    logic [CNT_W-1:0]  wait_q,     wait_d;

    logic req_any;
    logic wait_expired;

    assign req_any      = load_i | store_i;
    assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        prev_req_d = req_any;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        res_hi_d   = res_hi_q;
        wait_d     = wait_q;

        case (state_q)
            S_IDLE: begin
                // Only a fresh edge starts a command; a request still held from
                // the previous command (or raised during DONE) is ignored.
                if (req_any && !prev_req_q) begin
                    addr_d = addr_i;
                    req_d  = 1'b1;
                    wait_d = '0;
                    if (load_i) begin
                        state_d = S_READ;
                        we_d    = 1'b0;
                    end else begin
                        state_d  = S_WRITE_LO;
                        we_d     = 1'b1;
                        wdata_d  = result_i[7:0];
                        res_hi_d = result_i[15:8];
                    end
                end
            end
            S_READ, S_WRITE_LO, S_WRITE_HI: begin
                if (mem.mem_ack) begin
                    wait_d = '0;
                    if (state_q == S_WRITE_LO) begin
                        // Second beat: next byte address wraps naturally at ADDR_W bits.
                        state_d = S_WRITE_HI;
                        addr_d  = addr_q + ADDR_W'(1);
                        wdata_d = res_hi_q;
                    end else begin
                        if (state_q == S_READ) begin
                            data_d = mem.mem_rdata;
                        end
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end else if (wait_expired) begin
                    // Abort the whole command; a low-byte timeout skips the high byte.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            prev_req_q <= 1'b0;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            res_hi_q   <= 8'h00;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_req_q <= prev_req_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            res_hi_q   <= res_hi_d;
            wait_q     <= wait_d;
        end
    end

    assign data_o        = data_q;
    assign mem_done_o    = done_q;
    assign mem_err_o     = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
